rs_dsp_macc_seq: RTL and testbench
==================================

// Module: rs_dsp_macc_seq
// PURPOSE
//  Sequencer for one RS_DSP_MULTACC_REGIN_REGOUT: computes dot products sum(a[i]*b[i]), i=0..cfg_len-1.
//  Accepts a valid/ready operand stream, drives the DSP a/b/load_acc/mode pins, waits out DSP latency.
//  Captures z into a one-entry result register with valid/ready handshake. Sits between fabric logic and the DSP instance.
// PARAMETERS
//  LEN_W     8   width of cfg_len (vector length 1..2^LEN_W-1)
//  PIPE_LAT  2   clk edges from a dsp_* output update until dsp_z reflects it
// PORTS
//  clk              in   1    clock, rising edge
//  lreset           in   1    reset, asynchronous, active-high
//  start            in   1    begin a vector; sampled only in IDLE
//  abort            in   1    cancel current operation; priority over all other inputs
//  cfg_len          in   LEN_W  products per vector; sampled with start
//  cfg_unsigned_a/b in   1    operand signedness; sampled with start
//  cfg_sat,cfg_round,cfg_sub in 1  saturate/round/subtract; sampled with start
//  cfg_shift        in   6    accumulator right shift; sampled with start
//  busy             out  1    state != IDLE
//  in_valid,in_ready in/out 1  operand handshake
//  in_a / in_b      in   20/18  operands
//  dsp_a / dsp_b    out  20/18  to DSP a/b
//  dsp_load_acc     out  1    1: acc := product; 0: acc += product
//  dsp_feedback     out  3    constant 3'b000
//  dsp_unsigned_a/b,dsp_saturate_enable,dsp_round,dsp_subtract out 1  latched cfg
//  dsp_shift_right  out  6    latched cfg_shift
//  dsp_z            in   38   DSP result
//  res_valid,res_ready out/in 1  result handshake
//  res_data         out  38   captured dot product
// BEHAVIOUR
//  - Reset: state IDLE; every output 0; counters cleared.
//  - FSM IDLE -> RUN -> DRAIN -> RESULT -> IDLE; abort at any edge -> IDLE, res_valid 0, dsp_a/b/load_acc 0.
//  - IDLE: start=1 and cfg_len!=0 -> latch cfg, elem count := 0, go RUN. cfg_len==0: start ignored.
//  - RUN: in_ready=1 (registered from state only). Handshake edge: dsp_a<=in_a, dsp_b<=in_b,
//    dsp_load_acc<=(count==0), count++. No handshake: dsp_a/b<=0, dsp_load_acc<=0 (bubble adds zero).
//  - Last handshake (count==cfg_len-1) at edge E -> DRAIN; dsp_a/b/load_acc zeroed from E+1.
//  - DRAIN: res_data<=dsp_z and res_valid<=1 at edge E+PIPE_LAT+1 -> RESULT.
//  - RESULT: res_data/res_valid held until res_valid&&res_ready; that edge -> IDLE, res_valid 0.
//    Next start accepted one cycle later at earliest.
//  - start while busy ignored; in_ready=0 outside RUN; cfg changes outside IDLE have no effect.
//  - Latched mode outputs stay constant from start acceptance until return to IDLE.
//  - Arithmetic done in the DSP; block is width-transparent (20x18 -> 38, signedness per cfg).
// STRUCTURE
//  - Shared package/include rs_dsp_pkg: A_W=20, B_W=18, Z_W=38, SHIFT_W=6, FSM state encodings.
//  - Single flat module: FSM, element counter, drain counter ($clog2(PIPE_LAT+1) bits), result register.
//  - No sub-module; the DSP is instantiated by the parent, not in this block.
// TESTING (bench models DSP with PIPE_LAT=2)
//  1 len=3, unsigned, a={1,2,3}, b={4,5,6}, no gaps -> load_acc only on first; res_data=32 at last edge+3.
//  2 Same vector, in_valid low 2 cycles between elements -> dsp_a/b=0 in gaps; res_data=32.
//  3 len=1, signed, a=-2, b=3 -> dsp_unsigned_a=0; res_data=38'h3FFFFFFFFA.
//  4 res_ready low 10 cycles after result -> res_data held, in_ready=0, start ignored; then handshake -> IDLE.
//  5 abort after 2 of 4 elements -> IDLE next edge, no res_valid; next len=1 a=7 b=7 -> res_data=49.
//  6 lreset in DRAIN -> all outputs 0 immediately; start with cfg_len=0 -> busy stays 0.

Source files
------------

// File: rtl/rs_dsp_pkg.sv
// rs_dsp_pkg: widths and FSM encoding shared by the DSP sequencers.
// Operand/result widths match RS_DSP_MULTACC_REGIN_REGOUT (20x18 -> 38).
package rs_dsp_pkg;

  localparam int A_W     = 20;
  localparam int B_W     = 18;
  localparam int Z_W     = 38;
  localparam int SHIFT_W = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RESULT = 2'd3
  } state_e;

  typedef struct packed {
    logic               ua;
    logic               ub;
    logic               sat;
    logic               rnd;
    logic               sub;
    logic [SHIFT_W-1:0] shift;
  } mode_t;

endpackage

// File: rtl/rs_dsp_macc_seq.sv
// rs_dsp_macc_seq: feeds one MULTACC DSP a dot product sum(a[i]*b[i]).
// Ports: start/abort/cfg_* control, in_* operand stream (valid/ready),
// dsp_* pins to the DSP, dsp_z back, res_* result (valid/ready), busy.
module rs_dsp_macc_seq
  import rs_dsp_pkg::*;
#(
  parameter int LEN_W    = 8,
  parameter int PIPE_LAT = 2
) (
  input  logic               clk,
  input  logic               lreset,
  input  logic               start,
  input  logic               abort,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_unsigned_a,
  input  logic               cfg_unsigned_b,
  input  logic               cfg_sat,
  input  logic               cfg_round,
  input  logic               cfg_sub,
  input  logic [SHIFT_W-1:0] cfg_shift,
  output logic               busy,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  output logic [A_W-1:0]     dsp_a,
  output logic [B_W-1:0]     dsp_b,
  output logic               dsp_load_acc,
  output logic [2:0]         dsp_feedback,
  output logic               dsp_unsigned_a,
  output logic               dsp_unsigned_b,
  output logic               dsp_saturate_enable,
  output logic               dsp_round,
  output logic               dsp_subtract,
  output logic [SHIFT_W-1:0] dsp_shift_right,
  input  logic [Z_W-1:0]     dsp_z,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [Z_W-1:0]     res_data
);

  localparam int DW = $clog2(PIPE_LAT + 1);

  state_e           state;
  state_e           state_nxt;
  mode_t            mode_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [DW-1:0]    drain_cnt;
  logic             hs;
  logic             last;
  logic             drain_done;

  assign hs         = in_valid && in_ready;
  assign last       = hs && (cnt == len_q - LEN_W'(1));
  assign drain_done = (drain_cnt == DW'(PIPE_LAT));

  assign busy                = (state != ST_IDLE);
  assign dsp_feedback        = 3'b000;
  assign dsp_unsigned_a      = mode_q.ua;
  assign dsp_unsigned_b      = mode_q.ub;
  assign dsp_saturate_enable = mode_q.sat;
  assign dsp_round           = mode_q.rnd;
  assign dsp_subtract        = mode_q.sub;
  assign dsp_shift_right     = mode_q.shift;

  always_ff @(posedge clk or posedge lreset) begin
    if (lreset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE:
          if (start && cfg_len != '0) state_nxt = ST_RUN;
        ST_RUN:
          if (last) state_nxt = ST_DRAIN;
        ST_DRAIN:
          if (drain_done) state_nxt = ST_RESULT;
        ST_RESULT:
          if (res_ready) state_nxt = ST_IDLE;
        default:
          state_nxt = ST_IDLE;
      endcase
    end
  end

  // dsp_a/b/load_acc default to zero every cycle so that
  // bubbles and the drain phase accumulate nothing.
  always_ff @(posedge clk or posedge lreset) begin
    if (lreset) begin
      in_ready     <= 1'b0;
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_load_acc <= 1'b0;
      mode_q       <= '0;
      len_q        <= '0;
      cnt          <= '0;
      drain_cnt    <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
    end else begin
      in_ready     <= (state_nxt == ST_RUN);
      dsp_a        <= '0;
      dsp_b        <= '0;
      dsp_load_acc <= 1'b0;
      if (abort) begin
        res_valid <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (start && cfg_len != '0) begin
              mode_q.ua    <= cfg_unsigned_a;
              mode_q.ub    <= cfg_unsigned_b;
              mode_q.sat   <= cfg_sat;
              mode_q.rnd   <= cfg_round;
              mode_q.sub   <= cfg_sub;
              mode_q.shift <= cfg_shift;
              len_q        <= cfg_len;
              cnt          <= '0;
            end
          end
          ST_RUN: begin
            if (hs) begin
              dsp_a        <= in_a;
              dsp_b        <= in_b;
              dsp_load_acc <= (cnt == '0);
              cnt          <= cnt + LEN_W'(1);
              if (last) drain_cnt <= '0;
            end
          end
          ST_DRAIN: begin
            if (drain_done) begin
              res_data  <= dsp_z;
              res_valid <= 1'b1;
            end else begin
              drain_cnt <= drain_cnt + DW'(1);
            end
          end
          ST_RESULT: begin
            if (res_ready) res_valid <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rs_dsp_macc_seq.sv
// tb_rs_dsp_macc_seq: directed vectors against a 2-edge DSP model.
// Inputs driven and outputs sampled on the falling edge.
module tb_rs_dsp_macc_seq;

  logic        clk = 1'b0;
  logic        lreset;
  logic        start, abort;
  logic [7:0]  cfg_len;
  logic        cfg_unsigned_a, cfg_unsigned_b;
  logic        cfg_sat, cfg_round, cfg_sub;
  logic [5:0]  cfg_shift;
  logic        busy;
  logic        in_valid, in_ready;
  logic [19:0] in_a, dsp_a;
  logic [17:0] in_b, dsp_b;
  logic        dsp_load_acc;
  logic [2:0]  dsp_feedback;
  logic        dsp_unsigned_a, dsp_unsigned_b;
  logic        dsp_saturate_enable, dsp_round, dsp_subtract;
  logic [5:0]  dsp_shift_right;
  logic [37:0] dsp_z;
  logic        res_valid, res_ready;
  logic [37:0] res_data;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rs_dsp_macc_seq #(.LEN_W(8), .PIPE_LAT(2)) dut (
    .clk                 (clk),
    .lreset              (lreset),
    .start               (start),
    .abort               (abort),
    .cfg_len             (cfg_len),
    .cfg_unsigned_a      (cfg_unsigned_a),
    .cfg_unsigned_b      (cfg_unsigned_b),
    .cfg_sat             (cfg_sat),
    .cfg_round           (cfg_round),
    .cfg_sub             (cfg_sub),
    .cfg_shift           (cfg_shift),
    .busy                (busy),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .in_a                (in_a),
    .in_b                (in_b),
    .dsp_a               (dsp_a),
    .dsp_b               (dsp_b),
    .dsp_load_acc        (dsp_load_acc),
    .dsp_feedback        (dsp_feedback),
    .dsp_unsigned_a      (dsp_unsigned_a),
    .dsp_unsigned_b      (dsp_unsigned_b),
    .dsp_saturate_enable (dsp_saturate_enable),
    .dsp_round           (dsp_round),
    .dsp_subtract        (dsp_subtract),
    .dsp_shift_right     (dsp_shift_right),
    .dsp_z               (dsp_z),
    .res_valid           (res_valid),
    .res_ready           (res_ready),
    .res_data            (res_data)
  );

  // DSP model: inputs registered on one edge, accumulator on the next.
  logic [19:0] r_a;
  logic [17:0] r_b;
  logic        r_ld;
  logic [37:0] acc;
  logic [37:0] ea, eb, prod;

  always_comb begin
    ea   = dsp_unsigned_a ? {18'b0, r_a} : {{18{r_a[19]}}, r_a};
    eb   = dsp_unsigned_b ? {20'b0, r_b} : {{20{r_b[17]}}, r_b};
    prod = ea * eb;
  end

  always_ff @(posedge clk or posedge lreset) begin
    if (lreset) begin
      r_a  <= '0;
      r_b  <= '0;
      r_ld <= 1'b0;
      acc  <= '0;
    end else begin
      r_a  <= dsp_a;
      r_b  <= dsp_b;
      r_ld <= dsp_load_acc;
      if (r_ld)              acc <= dsp_subtract ? -prod : prod;
      else if (dsp_subtract) acc <= acc - prod;
      else                   acc <= acc + prod;
    end
  end

  assign dsp_z = acc;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic begin_vec(input int len, input logic ua, input logic ub);
    cfg_len        = 8'(len);
    cfg_unsigned_a = ua;
    cfg_unsigned_b = ub;
    start          = 1'b1;
    tick();
    start          = 1'b0;
    cfg_len        = 8'd0;
    chk("busy_after_start", busy, 1);
    chk("in_ready_run", in_ready, 1);
    chk("mode_ua", dsp_unsigned_a, ua);
  endtask

  task automatic run_vec(input string tag, input int len,
                         input logic ua, input logic ub,
                         input logic [19:0] av [4],
                         input logic [17:0] bv [4],
                         input int gap, input int hold,
                         input logic [37:0] exp);
    int n;
    begin_vec(len, ua, ub);
    for (int i = 0; i < len; i++) begin
      in_valid = 1'b1;
      in_a     = av[i];
      in_b     = bv[i];
      tick();
      chk({tag, "_dsp_a"}, dsp_a, av[i]);
      chk({tag, "_dsp_b"}, dsp_b, bv[i]);
      chk({tag, "_load"}, dsp_load_acc, (i == 0));
      in_valid = 1'b0;
      in_a     = 20'hABCDE;
      in_b     = 18'h2BCDE;
      if (i < len - 1) begin
        for (int g = 0; g < gap; g++) begin
          tick();
          chk({tag, "_gap_a"}, dsp_a, 0);
          chk({tag, "_gap_ld"}, dsp_load_acc, 0);
        end
      end
    end
    chk({tag, "_in_ready_drain"}, in_ready, 0);
    n = 0;
    while (!res_valid && n < 10) begin
      tick();
      n++;
      if (n == 1) chk({tag, "_drain_a"}, dsp_a, 0);
    end
    chk({tag, "_latency"}, n, 3);
    chk({tag, "_res"}, res_data, exp);
    for (int h = 0; h < hold; h++) begin
      start   = 1'b1;
      cfg_len = 8'd1;
      tick();
      chk({tag, "_hold_v"}, res_valid, 1);
      chk({tag, "_hold_d"}, res_data, exp);
      chk({tag, "_hold_rdy"}, in_ready, 0);
    end
    start     = 1'b0;
    cfg_len   = 8'd0;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_done_v"}, res_valid, 0);
    chk({tag, "_done_busy"}, busy, 0);
  endtask

  logic [19:0] va [4];
  logic [17:0] vb [4];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    lreset         = 1'b1;
    start          = 1'b0;
    abort          = 1'b0;
    cfg_len        = 8'd0;
    cfg_unsigned_a = 1'b0;
    cfg_unsigned_b = 1'b0;
    cfg_sat        = 1'b0;
    cfg_round      = 1'b0;
    cfg_sub        = 1'b0;
    cfg_shift      = 6'd0;
    in_valid       = 1'b0;
    in_a           = '0;
    in_b           = '0;
    res_ready      = 1'b0;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_dsp_a", dsp_a, 0);
    chk("rst_feedback", dsp_feedback, 0);
    lreset = 1'b0;
    tick();

    // 1: unsigned {1,2,3}.{4,5,6} = 32, back to back
    va = '{20'd1, 20'd2, 20'd3, 20'd0};
    vb = '{18'd4, 18'd5, 18'd6, 18'd0};
    run_vec("t1", 3, 1'b1, 1'b1, va, vb, 0, 0, 38'd32);
    tick();

    // 2: same vector with two-cycle bubbles
    run_vec("t2", 3, 1'b1, 1'b1, va, vb, 2, 0, 38'd32);
    tick();

    // 3: signed -2 * 3 = -6
    va = '{20'hFFFFE, 20'd0, 20'd0, 20'd0};
    vb = '{18'd3, 18'd0, 18'd0, 18'd0};
    run_vec("t3", 1, 1'b0, 1'b0, va, vb, 0, 0, 38'h3FFFFFFFFA);
    tick();

    // 4: result held for 10 cycles of backpressure
    va = '{20'd1, 20'd2, 20'd3, 20'd0};
    vb = '{18'd4, 18'd5, 18'd6, 18'd0};
    run_vec("t4", 3, 1'b1, 1'b1, va, vb, 0, 10, 38'd32);
    tick();
    chk("t4_idle_after", busy, 0);

    // 5: abort after 2 of 4 elements
    begin_vec(4, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 20'd5;
      in_b     = 18'd5;
      tick();
    end
    in_valid = 1'b0;
    abort    = 1'b1;
    tick();
    abort    = 1'b0;
    chk("t5_abort_busy", busy, 0);
    chk("t5_abort_rdy", in_ready, 0);
    chk("t5_abort_a", dsp_a, 0);
    chk("t5_abort_ld", dsp_load_acc, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t5_no_res", res_valid, 0);
    end
    va = '{20'd7, 20'd0, 20'd0, 20'd0};
    vb = '{18'd7, 18'd0, 18'd0, 18'd0};
    run_vec("t5", 1, 1'b1, 1'b1, va, vb, 0, 0, 38'd49);
    tick();

    // 6: async reset while draining, then zero-length start
    begin_vec(2, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_a     = 20'd9;
      in_b     = 18'd9;
      tick();
    end
    in_valid = 1'b0;
    tick();
    chk("t6_in_drain", busy, 1);
    #2;
    lreset = 1'b1;
    #1;
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ua", dsp_unsigned_a, 0);
    chk("t6_rst_rv", res_valid, 0);
    chk("t6_rst_a", dsp_a, 0);
    tick();
    lreset  = 1'b0;
    tick();
    cfg_len = 8'd0;
    start   = 1'b1;
    tick();
    chk("t6_len0_busy", busy, 0);
    tick();
    start   = 1'b0;
    chk("t6_len0_busy2", busy, 0);
    chk("t6_len0_rdy", in_ready, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
